// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard / stall / flush controller for a classic 5-stage pipeline.
//   Decides, every cycle, which pipeline latches advance (en) or are cleared
//   (flush), tracks a data-cache wait and a sticky halt, and counts the
//   cycles in which the PC was held.
//
// Ports
//   CLK, nRST                 : clock, asynchronous active-low reset
//   ihit, dhit                : instruction / data access completed this cycle
//   dmemREN_MEM, dmemWEN_MEM  : load / store occupying MEM
//   MemRead_EX, rt_EX         : load in EX and its destination register
//   rs_ID, rt_ID              : source registers of the ID instruction
//   redirect_EX               : taken branch / jump resolved in EX
//   halt_WB                   : halt instruction reached WB
//   pc_en, *_en, *_flush      : latch controls (combinational)
//   halt                      : sticky halted flag (registered)
//   state                     : RUN=0, DWAIT=1, HALT=2 (registered)
//   stall_cnt                 : saturating count of PC-held cycles (registered)
// ---------------------------------------------------------------------------
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmemREN_MEM,
    input  logic        dmemWEN_MEM,
    input  logic        MemRead_EX,
    input  logic [4:0]  rt_EX,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        redirect_EX,
    input  logic        halt_WB,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        memwb_en,
    output logic        memwb_flush,
    output logic        halt,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        fetched_q, fetched_d;
    logic        halt_q, halt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        dstall_s;
    logic        hz_s;
    logic        istall_s;

    // Hazard detection terms
    always_comb begin
        dstall_s = (dmemREN_MEM | dmemWEN_MEM) & ~dhit;
        hz_s     = MemRead_EX & (rt_EX != 5'd0) &
                   ((rt_EX == rs_ID) | (rt_EX == rt_ID));
        // An instruction already captured during a back-end stall must not
        // be treated as a pending miss.
        istall_s = ~ihit & ~fetched_q;
    end

    // Latch enable / flush priority decode
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        if (state_q == ST_HALT) begin
            pc_en = 1'b0;
        end else if (dstall_s) begin
            pc_en = 1'b0;
        end else if (redirect_EX) begin
            // Redirect outranks istall and hz: move the PC and kill the
            // wrong-path instructions in IF/ID and ID/EX.
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (istall_s | hz_s) begin
            // Hold front end, inject a bubble into EX, let the back end drain.
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

    // Next-state logic for FSM, fetched flag, halt flag and stall counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dstall_s) begin
                    state_d = ST_DWAIT;
                end else if (halt_WB) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DWAIT: begin
                if (halt_WB & ~dstall_s) begin
                    state_d = ST_HALT;
                end else if (dhit) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DWAIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (ifid_en | ifid_flush) begin
            fetched_d = 1'b0;
        end else if (ihit) begin
            fetched_d = 1'b1;
        end else begin
            fetched_d = fetched_q;
        end

        halt_d = (state_d == ST_HALT);

        if ((state_q != ST_HALT) && !pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            fetched_q   <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            fetched_q   <= fetched_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halt      = halt_q;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios with literal expectations, a long sustained load-use
//   run to reach counter saturation, then randomized traffic. A behavioural
//   model checks every DUT output on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dmemREN_MEM, dmemWEN_MEM, MemRead_EX;
    logic [4:0]  rt_EX, rs_ID, rt_ID;
    logic        redirect_EX, halt_WB;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic        halt;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemREN_MEM(dmemREN_MEM), .dmemWEN_MEM(dmemWEN_MEM),
        .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .redirect_EX(redirect_EX), .halt_WB(halt_WB),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halt(halt), .state(state), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; dmemREN_MEM = 1'b0; dmemWEN_MEM = 1'b0;
        MemRead_EX = 1'b0; rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
        redirect_EX = 1'b0; halt_WB = 1'b0;
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Behavioural reference: checked on every falling edge, then advanced
    // with the inputs that will be sampled at the following rising edge.
    int         m_state   = 0;
    bit         m_fetched = 1'b0;
    int         m_cnt     = 0;

    initial begin
        bit         dst, hzd, ist;
        logic [8:0] e;
        logic [8:0] got;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                m_state = 0; m_fetched = 1'b0; m_cnt = 0;
            end
            dst = (dmemREN_MEM || dmemWEN_MEM) && !dhit;
            hzd = MemRead_EX && (rt_EX != 5'd0) && (rt_EX == rs_ID || rt_EX == rt_ID);
            ist = !ihit && !m_fetched;
            // order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl
            if (m_state == 2)      e = 9'b0_0_0_0_0_0_0_0_0;
            else if (dst)          e = 9'b0_0_0_0_0_0_0_0_0;
            else if (redirect_EX)  e = 9'b1_0_1_0_1_1_0_1_0;
            else if (ist || hzd)   e = 9'b0_0_0_0_1_1_0_1_0;
            else                   e = 9'b1_1_0_1_0_1_0_1_0;
            got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, memwb_flush};
            chk("model_ctrl", 32'(got), 32'(e));
            chk("model_state", 32'(state), 32'(m_state));
            chk("model_halt", 32'(halt), (m_state == 2) ? 32'd1 : 32'd0);
            chk("model_cnt", 32'(stall_cnt), 32'(m_cnt));
            if (nRST) begin
                if (m_state != 2 && !e[8] && m_cnt < 65535) m_cnt = m_cnt + 1;
                if (e[7] || e[6])  m_fetched = 1'b0;
                else if (ihit)     m_fetched = 1'b1;
                if (m_state != 2) begin
                    if (dst)                        m_state = 1;
                    else if (halt_WB)               m_state = 2;
                    else if (m_state == 1 && dhit)  m_state = 0;
                end
            end
        end
    end

    initial begin
        idle();
        nRST = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        cyc(); cyc();
        nRST = 1'b1;

        // load-use bubble
        cyc();
        MemRead_EX = 1'b1; rt_EX = 5'd8; rs_ID = 5'd8; ihit = 1'b1;
        #1;
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_ifid_en", 32'(ifid_en), 32'd0);
        chk("lu_idex_flush", 32'(idex_flush), 32'd1);
        chk("lu_exmem_en", 32'(exmem_en), 32'd1);
        chk("lu_cnt0", 32'(stall_cnt), 32'd0);
        cyc(); idle(); #1;
        chk("lu_cnt1", 32'(stall_cnt), 32'd1);

        // dcache miss for three cycles
        cyc(); dmemREN_MEM = 1'b1; dhit = 1'b0; #1;
        chk("dm_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
        cyc(); #1;
        chk("dm_state", 32'(state), 32'd1);
        cyc(); cyc(); dhit = 1'b1; #1;
        chk("dm_release_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'h1F);
        cyc(); idle(); #1;
        chk("dm_state_run", 32'(state), 32'd0);
        chk("dm_cnt", 32'(stall_cnt), 32'd4);

        // fetch during dstall must not be re-requested
        cyc(); dmemREN_MEM = 1'b1; dhit = 1'b0; ihit = 1'b0;
        cyc(); ihit = 1'b1;
        cyc(); dhit = 1'b1; ihit = 1'b0; #1;
        chk("fd_ifid_en", 32'(ifid_en), 32'd1);
        chk("fd_pc_en", 32'(pc_en), 32'd1);
        chk("fd_idex_flush", 32'(idex_flush), 32'd0);
        cyc(); idle(); ihit = 1'b0; #1;
        chk("fd_cleared_pc_en", 32'(pc_en), 32'd0);
        chk("fd_cleared_flush", 32'(idex_flush), 32'd1);

        // redirect during icache miss, with a simultaneous load-use hazard
        cyc(); idle(); ihit = 1'b0; redirect_EX = 1'b1;
        MemRead_EX = 1'b1; rt_EX = 5'd5; rt_ID = 5'd5; #1;
        chk("rd_pc_en", 32'(pc_en), 32'd1);
        chk("rd_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rd_idex_flush", 32'(idex_flush), 32'd1);
        chk("rd_ifid_en", 32'(ifid_en), 32'd0);
        cyc(); idle();

        // halt requested during dstall: wait for dhit first
        cyc(); halt_WB = 1'b1; dmemREN_MEM = 1'b1; dhit = 1'b0; #1;
        chk("hd_pc_en", 32'(pc_en), 32'd0);
        cyc(); #1;
        chk("hd_state_dwait", 32'(state), 32'd1);
        chk("hd_halt0", 32'(halt), 32'd0);
        dhit = 1'b1;
        cyc(); idle(); #1;
        chk("hd_state_halt", 32'(state), 32'd2);
        chk("hd_halt1", 32'(halt), 32'd1);
        chk("hd_en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
        cyc(); #1;
        chk("hd_sticky", 32'(state), 32'd2);
        nRST = 1'b0; #1;
        chk("hd_rst_state", 32'(state), 32'd0);
        chk("hd_rst_halt", 32'(halt), 32'd0);
        chk("hd_rst_cnt", 32'(stall_cnt), 32'd0);
        cyc(); nRST = 1'b1;

        // reset mid-DWAIT
        cyc(); dmemREN_MEM = 1'b1; dhit = 1'b0;
        cyc(); #1;
        chk("rdw_state", 32'(state), 32'd1);
        nRST = 1'b0; #1;
        chk("rdw_rst_state", 32'(state), 32'd0);
        chk("rdw_rst_cnt", 32'(stall_cnt), 32'd0);
        cyc(); nRST = 1'b1; idle();

        // counter saturation via sustained load-use hazard
        cyc(); MemRead_EX = 1'b1; rt_EX = 5'd3; rs_ID = 5'd3;
        repeat (65540) cyc();
        #1;
        chk("sat_cnt", 32'(stall_cnt), 32'h0000FFFF);
        cyc(); #1;
        chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        nRST = 1'b0; idle();
        cyc(); nRST = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            ihit        = ($urandom_range(0, 3) != 0);
            dhit        = ($urandom_range(0, 2) == 0);
            dmemREN_MEM = ($urandom_range(0, 3) == 0);
            dmemWEN_MEM = ($urandom_range(0, 5) == 0);
            MemRead_EX  = ($urandom_range(0, 2) == 0);
            rt_EX       = 5'($urandom_range(0, 3));
            rs_ID       = 5'($urandom_range(0, 3));
            rt_ID       = 5'($urandom_range(0, 3));
            redirect_EX = ($urandom_range(0, 5) == 0);
            halt_WB     = ($urandom_range(0, 199) == 0);
            nRST        = ($urandom_range(0, 79) != 0);
        end
        cyc(); nRST = 1'b1; idle();
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: CLK input 1 system clock; nRST input 1 asynchronous active-low reset.
REQ-002 The block SHALL have the following inputs:
- ihit, 1 bit: instruction fetch complete this cycle.
- dhit, 1 bit: data access complete this cycle.
- dmemREN_MEM and dmemWEN_MEM, 1 bit each: load or store occupying MEM.
- MemRead_EX, 1 bit: load in EX.
- rt_EX, 5 bits: destination register of the EX load.
- rs_ID and rt_ID, 5 bits each: source registers in ID.
- redirect_EX, 1 bit: branch taken or jump resolved in EX.
- halt_WB, 1 bit: halt instruction in WB.
REQ-003 The block SHALL have the following 1-bit outputs:
- pc_en: PC update.
- ifid_en, ifid_flush.
- idex_en, idex_flush.
- exmem_en, exmem_flush.
- memwb_en, memwb_flush.
- halt: sticky, CPU halted.
REQ-004 The block SHALL have the following 2-bit output: state, current FSM state (RUN=0, DWAIT=1, HALT=2).
REQ-005 The block SHALL have the following 16-bit output: stall_cnt, count of stalled cycles.

Function
REQ-006 Definitions:
- dstall = (dmemREN_MEM | dmemWEN_MEM) & ~dhit.
- hz = MemRead_EX & (rt_EX != 0) & (rt_EX == rs_ID | rt_EX == rt_ID).
- istall = ~ihit & ~fetched, where fetched is an internal 1-bit register.
REQ-007 Outputs other than halt, state and stall_cnt SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-008 In HALT, all en and flush outputs SHALL be 0 and halt SHALL be 1.
REQ-009 Outside HALT, the first matching rule SHALL apply:
- (a) dstall: all en=0, all flush=0.
- (b) redirect_EX: pc_en=1; ifid_flush=1; idex_flush=1; exmem_en=1; memwb_en=1; ifid_en=0; idex_en=0.
- (c) istall: pc_en=0; ifid_en=0; idex_flush=1; exmem_en=1; memwb_en=1.
- (d) hz: pc_en=0; ifid_en=0; idex_flush=1; exmem_en=1; memwb_en=1.
- (e) otherwise: all en=1, all flush=0.
REQ-010 For each latch, en and flush SHALL never both be 1 in the same cycle; latch enable beats flush.
REQ-011 exmem_flush and memwb_flush SHALL always be 0 outside reset.
REQ-012 Redirect SHALL take precedence over istall, so a redirect during an icache miss moves the PC and kills the wrong-path ID instruction.
REQ-013 FSM transitions:
- RUN->DWAIT when dstall.
- DWAIT->RUN on the cycle dhit=1.
- RUN or DWAIT->HALT when halt_WB=1 and dstall=0.
- HALT exits only by reset.
REQ-014 fetched SHALL update as follows:
- Set to 1 at the clock edge when ihit=1 and ifid_en=0 and ifid_flush=0.
- Cleared when ifid_en=1 or ifid_flush=1.
- Holds otherwise.
- This prevents an instruction fetched during a back-end stall from being re-requested.
REQ-015 stall_cnt SHALL increment by 1 on each edge where state≠HALT and pc_en=0, SHALL saturate at 16'hFFFF, and SHALL hold in HALT.
REQ-016 When halt_WB and dstall are both 1, dstall SHALL win and halt SHALL be entered only after dhit.
REQ-017 When redirect_EX and hz are both 1, redirect SHALL win and the load-use bubble SHALL be suppressed.

Reset
REQ-018 On nRST=0, asynchronously: state=RUN, fetched=0, stall_cnt=0, halt=0.
REQ-019 During reset, combinational outputs SHALL follow REQ-009 from state RUN.
REQ-020 When reset is asserted mid-DWAIT or in HALT, the block SHALL return to RUN, halt=0 and stall_cnt=0 immediately, without waiting for a clock edge.

Verification
REQ-021 Load-use: MemRead_EX=1, rt_EX=8, rs_ID=8, ihit=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; stall_cnt 0->1.
REQ-022 Dcache miss: dmemREN_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> all en=0 for 3 cycles, state=DWAIT, then all en=1, state=RUN, stall_cnt=3.
REQ-023 Fetch during dstall: ihit=1 in cycle 2 of a dstall, then ihit=0 after dhit -> fetched=1, no istall on release, ifid_en=1, then fetched=0.
REQ-024 Redirect during icache miss: ihit=0, redirect_EX=1 -> pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=0.
REQ-025 Halt: halt_WB=1 with dstall=0 -> next edge state=2, halt=1, all en=0; nRST pulse -> state=0, halt=0.
REQ-026 Saturation: stall_cnt preloaded to 16'hFFFF by sustained hz -> stays 16'hFFFF.
